// File: rtl/qspi_mem_pkg.sv
// Shared definitions for the dual/quad-SPI word-memory initiator.
//   CMD_WRITE/CMD_READ : command codes sent as the first byte
//   ADDR_W/WORD_W/...  : field widths
//   state_e            : transaction FSM states
//   cmd_t              : burst request captured on accept
package qspi_mem_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 8;

  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h01;
  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h02;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SS_LEAD,
    S_CMD,
    S_ADDR_H,
    S_ADDR_L,
    S_WR_LSB,
    S_WR_MSB,
    S_DUMMY,
    S_RD_MSB,
    S_RD_LSB,
    S_SS_TRAIL,
    S_GAP
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
  } cmd_t;

  // States in which one byte is clocked across the serial link.
  function automatic logic is_byte_state(input state_e s);
    return (s inside {S_CMD, S_ADDR_H, S_ADDR_L, S_WR_LSB, S_WR_MSB,
                      S_DUMMY, S_RD_MSB, S_RD_LSB});
  endfunction

endpackage

// File: rtl/qspi_master_shifter.sv
// SCLK generator and byte shifter for the QSPI initiator.
// One start pulse clocks one byte: DWIDTH bits per SCLK period, MSB first.
// Outgoing bits change while SCLK is low, incoming bits are captured on the
// CLK edge that raises SCLK. SCLK idles low between bytes.
//   CLK, RST         : clock, synchronous active-high reset
//   start_i          : launch a byte (honoured only while idle)
//   tx_byte_i        : byte to send
//   rx_byte_o        : last fully received byte
//   rx_next_c        : receive register including the bits on QD_IN now
//   sample_last_c    : current edge captures the final bits of the byte
//   byte_done_o      : pulse, byte finished and SCLK back low
//   sclk_o/qd_out_o  : serial clock and outgoing lanes
//   qd_in_i          : incoming lanes
module qspi_master_shifter
  import qspi_mem_pkg::*;
#(
  parameter int unsigned DWIDTH = 2,
  parameter int unsigned CLKDIV = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start_i,
  input  logic [BYTE_W-1:0] tx_byte_i,
  output logic [BYTE_W-1:0] rx_byte_o,
  output logic [BYTE_W-1:0] rx_next_c,
  output logic              sample_last_c,
  output logic              byte_done_o,
  output logic              sclk_o,
  output logic [DWIDTH-1:0] qd_out_o,
  input  logic [DWIDTH-1:0] qd_in_i
);

  localparam int unsigned BEATS  = BYTE_W / DWIDTH;
  localparam int unsigned BEAT_W = 3;
  localparam int unsigned DIV_W  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic              active_q, active_d;
  logic              sclk_q,   sclk_d;
  logic [DIV_W-1:0]  div_q,    div_d;
  logic [BEAT_W-1:0] beat_q,   beat_d;
  logic [BYTE_W-1:0] tx_q,     tx_d;
  logic [BYTE_W-1:0] rx_q,     rx_d;
  logic [DWIDTH-1:0] qd_q,     qd_d;
  logic              done_q,   done_d;
  logic              half_end;

  assign half_end      = (div_q == DIV_W'(CLKDIV - 1));
  assign rx_next_c     = BYTE_W'({rx_q, qd_in_i});
  assign sample_last_c = active_q && !sclk_q && half_end &&
                         (beat_q == BEAT_W'(BEATS - 1));

  // Half-period counter; SCLK toggles when it wraps.
  always_comb begin : shift_next
    active_d = active_q;
    sclk_d   = sclk_q;
    div_d    = div_q;
    beat_d   = beat_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    qd_d     = qd_q;
    done_d   = 1'b0;
    if (!active_q) begin
      if (start_i) begin
        active_d = 1'b1;
        sclk_d   = 1'b0;
        div_d    = '0;
        beat_d   = '0;
        qd_d     = tx_byte_i[BYTE_W-1 -: DWIDTH];
        tx_d     = tx_byte_i << DWIDTH;
      end
    end else if (!half_end) begin
      div_d = div_q + DIV_W'(1);
    end else begin
      div_d = '0;
      if (!sclk_q) begin
        sclk_d = 1'b1;
        rx_d   = rx_next_c;
      end else begin
        sclk_d = 1'b0;
        if (beat_q == BEAT_W'(BEATS - 1)) begin
          active_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
          qd_d   = tx_q[BYTE_W-1 -: DWIDTH];
          tx_d   = tx_q << DWIDTH;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin : shift_regs
    if (RST) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      div_q    <= '0;
      beat_q   <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      qd_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      sclk_q   <= sclk_d;
      div_q    <= div_d;
      beat_q   <= beat_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      qd_q     <= qd_d;
      done_q   <= done_d;
    end
  end

  assign rx_byte_o   = rx_q;
  assign byte_done_o = done_q;
  assign sclk_o      = sclk_q;
  assign qd_out_o    = qd_q;

endmodule

// File: rtl/qspi_mem_master.sv
// Dual/quad-SPI initiator for the FPGA word-memory slave.
// Sends CMD, ADDR_H, ADDR_L, then streams 16-bit words (write: LSB,MSB;
// read: after dummy bytes, MSB,LSB) and returns read words.
//   CLK, RST                     : clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/len : burst request handshake
//   wr_data/wr_valid/wr_ready    : write word stream (wr_ready = consumed pulse)
//   rd_data/rd_valid             : read word stream, no backpressure
//   busy/done                    : transaction status
//   SS/SCLK/QD_OUT/QD_OE/QD_IN   : serial interface
module qspi_mem_master
  import qspi_mem_pkg::*;
#(
  parameter int unsigned DWIDTH      = 2,
  parameter int unsigned CLKDIV      = 2,
  parameter int unsigned DUMMY_BYTES = 1,
  parameter int unsigned SS_GAP      = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              SS,
  output logic              SCLK,
  output logic [DWIDTH-1:0] QD_OUT,
  output logic              QD_OE,
  input  logic [DWIDTH-1:0] QD_IN
);

  localparam int unsigned CNT_W = 16;

  state_e            state_q,     state_d;
  cmd_t              cmd_q,       cmd_d;
  logic              launched_q,  launched_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [LEN_W-1:0]  words_q,     words_d;
  logic [WORD_W-1:0] wlatch_q,    wlatch_d;
  logic [BYTE_W-1:0] msb_q,       msb_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              wr_ready_q,  wr_ready_d;
  logic [WORD_W-1:0] rd_data_q,   rd_data_d;
  logic              rd_valid_q,  rd_valid_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              ss_q,        ss_d;
  logic              qd_oe_q,     qd_oe_d;

  logic              sh_start;
  logic [BYTE_W-1:0] sh_tx;
  logic [BYTE_W-1:0] sh_rx;
  logic [BYTE_W-1:0] sh_rx_next;
  logic              sh_sample_last;
  logic              byte_done;
  logic              launch_ok;
  logic              last_word;

  qspi_master_shifter #(
    .DWIDTH (DWIDTH),
    .CLKDIV (CLKDIV)
  ) u_shifter (
    .CLK           (CLK),
    .RST           (RST),
    .start_i       (sh_start),
    .tx_byte_i     (sh_tx),
    .rx_byte_o     (sh_rx),
    .rx_next_c     (sh_rx_next),
    .sample_last_c (sh_sample_last),
    .byte_done_o   (byte_done),
    .sclk_o        (SCLK),
    .qd_out_o      (QD_OUT),
    .qd_in_i       (QD_IN)
  );

  assign last_word = (words_q == cmd_q.len);

  // Next-state: each byte state launches one byte, then advances on byte_done.
  always_comb begin : fsm_next
    state_d     = state_q;
    cmd_d       = cmd_q;
    launched_d  = launched_q;
    cnt_d       = cnt_q;
    words_d     = words_q;
    wlatch_d    = wlatch_q;
    msb_d       = msb_q;
    cmd_ready_d = cmd_ready_q;
    wr_ready_d  = 1'b0;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ss_d        = ss_q;
    qd_oe_d     = qd_oe_q;
    sh_start    = 1'b0;
    sh_tx       = '0;
    launch_ok   = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_d       = '{write: cmd_write, addr: cmd_addr, len: cmd_len};
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          ss_d        = 1'b0;
          qd_oe_d     = 1'b1;
          cnt_d       = '0;
          words_d     = '0;
          state_d     = S_SS_LEAD;
        end
      end
      S_SS_LEAD: begin
        if (cnt_q == CNT_W'(CLKDIV - 1)) begin
          cnt_d   = '0;
          state_d = S_CMD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CMD: begin
        sh_tx = cmd_q.write ? CMD_WRITE : CMD_READ;
        if (byte_done) state_d = S_ADDR_H;
      end
      S_ADDR_H: begin
        sh_tx = {4'b0000, cmd_q.addr[11:8]};
        if (byte_done) state_d = S_ADDR_L;
      end
      S_ADDR_L: begin
        sh_tx = cmd_q.addr[7:0];
        if (byte_done) begin
          if (cmd_q.write) begin
            state_d = S_WR_LSB;
          end else begin
            // Release the lanes so the slave can turn them around.
            qd_oe_d = 1'b0;
            cnt_d   = '0;
            state_d = (DUMMY_BYTES == 0) ? S_RD_MSB : S_DUMMY;
          end
        end
      end
      S_WR_LSB: begin
        // Stall here with SCLK low until a write word is offered.
        sh_tx     = wr_data[7:0];
        launch_ok = wr_valid;
        if (!launched_q && wr_valid) begin
          wlatch_d   = wr_data;
          wr_ready_d = 1'b1;
        end
        if (byte_done) state_d = S_WR_MSB;
      end
      S_WR_MSB: begin
        sh_tx = wlatch_q[15:8];
        if (byte_done) begin
          words_d = words_q + LEN_W'(1);
          cnt_d   = '0;
          state_d = last_word ? S_SS_TRAIL : S_WR_LSB;
        end
      end
      S_DUMMY: begin
        if (byte_done) begin
          if (cnt_q == CNT_W'(DUMMY_BYTES - 1)) begin
            state_d = S_RD_MSB;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_RD_MSB: begin
        if (byte_done) begin
          msb_d   = sh_rx;
          state_d = S_RD_LSB;
        end
      end
      S_RD_LSB: begin
        // Publish the word on the edge that captures its final bits.
        if (sh_sample_last) begin
          rd_data_d  = {msb_q, sh_rx_next};
          rd_valid_d = 1'b1;
        end
        if (byte_done) begin
          words_d = words_q + LEN_W'(1);
          cnt_d   = '0;
          state_d = last_word ? S_SS_TRAIL : S_RD_MSB;
        end
      end
      S_SS_TRAIL: begin
        if (cnt_q == CNT_W'(CLKDIV - 1)) begin
          ss_d    = 1'b1;
          qd_oe_d = 1'b0;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(SS_GAP - 1)) begin
          cnt_d       = '0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (is_byte_state(state_q) && !launched_q && launch_ok) begin
      sh_start   = 1'b1;
      launched_d = 1'b1;
    end
    if (byte_done) launched_d = 1'b0;
  end

  always_ff @(posedge CLK) begin : fsm_regs
    if (RST) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      launched_q  <= 1'b0;
      cnt_q       <= '0;
      words_q     <= '0;
      wlatch_q    <= '0;
      msb_q       <= '0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ss_q        <= 1'b1;
      qd_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      launched_q  <= launched_d;
      cnt_q       <= cnt_d;
      words_q     <= words_d;
      wlatch_q    <= wlatch_d;
      msb_q       <= msb_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ss_q        <= ss_d;
      qd_oe_q     <= qd_oe_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign SS        = ss_q;
  assign QD_OE     = qd_oe_q;

endmodule

// File: tb/tb_qspi_mem_master.sv
// Directed bench for qspi_mem_master with a 2-lane word-memory slave model.
module tb_qspi_mem_master;

  logic        CLK;
  logic        RST;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [11:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic        SS;
  logic        SCLK;
  logic [1:0]  QD_OUT;
  logic        QD_OE;
  logic [1:0]  QD_IN;

  int checks   = 0;
  int failures = 0;

  qspi_mem_master #(
    .DWIDTH (2), .CLKDIV (2), .DUMMY_BYTES (1), .SS_GAP (4)
  ) dut (
    .CLK (CLK), .RST (RST),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_write (cmd_write),
    .cmd_addr (cmd_addr), .cmd_len (cmd_len),
    .wr_data (wr_data), .wr_valid (wr_valid), .wr_ready (wr_ready),
    .rd_data (rd_data), .rd_valid (rd_valid),
    .busy (busy), .done (done),
    .SS (SS), .SCLK (SCLK), .QD_OUT (QD_OUT), .QD_OE (QD_OE), .QD_IN (QD_IN)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Slave memory and observation state.
  logic [15:0] mem [4096];
  logic [7:0]  byte_log [$];
  logic [15:0] rdq [$];
  logic [7:0]  scmd;
  logic [11:0] saddr;
  logic [7:0]  slo;
  logic [7:0]  sh;
  logic        prev_sclk;
  int          bc;
  int          rises;
  int          done_cnt;
  int          hi_run;
  int          gap_min;

  function automatic logic [15:0] pat(input logic [11:0] a);
    return {a[3:0], a} ^ 16'h3C5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic slave_byte(input int n, input logic [7:0] b);
    byte_log.push_back(b);
    if (n == 0) scmd = b;
    else if (n == 1) saddr[11:8] = b[3:0];
    else if (n == 2) saddr[7:0] = b;
    else if (scmd == 8'h01) begin
      if (((n - 3) % 2) == 0) slo = b;
      else mem[12'(saddr + 12'((n - 3) / 2))] = {b, slo};
    end
  endtask

  function automatic logic [1:0] slave_bits(input int beat);
    int n, p, k;
    logic [15:0] w;
    logic [7:0]  by;
    n = beat / 4;
    p = beat % 4;
    if (scmd != 8'h02 || n < 4) return 2'b00;
    k  = n - 4;
    w  = mem[12'(saddr + 12'(k / 2))];
    by = ((k % 2) == 0) ? w[15:8] : w[7:0];
    return 2'(by >> (6 - 2 * p));
  endfunction

  // Slave model: capture on SCLK rise, drive next bits after SCLK fall.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = pat(12'(i));
    QD_IN = 2'b00; prev_sclk = 1'b0; bc = 0; sh = '0; rises = 0;
    scmd = '0; saddr = '0; slo = '0;
    forever begin
      @(negedge CLK);
      if (SS) begin
        bc = 0;
        sh = '0;
      end else if (SCLK && !prev_sclk) begin
        rises++;
        sh = {sh[5:0], QD_OUT};
        if ((bc % 4) == 3) slave_byte(bc / 4, sh);
        bc++;
      end else if (!SCLK && prev_sclk) begin
        QD_IN = slave_bits(bc);
      end
      prev_sclk = SCLK;
    end
  end

  // Output monitors.
  initial begin
    done_cnt = 0; hi_run = 0; gap_min = 1000;
    forever begin
      @(negedge CLK);
      if (rd_valid) rdq.push_back(rd_data);
      if (done) done_cnt++;
      if (SS) hi_run++;
      else begin
        if (hi_run > 0 && hi_run < gap_min) gap_min = hi_run;
        hi_run = 0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic settle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic issue(input string tag, input logic w, input logic [11:0] a, input logic [7:0] l);
    bit got;
    byte_log.delete();
    rdq.delete();
    rises = 0;
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (cmd_ready) got = 1'b1;
      else @(negedge CLK);
    end
    @(negedge CLK);
    cmd_valid = 1'b0;
    check({tag, "_accept"}, 32'(got), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int max);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge CLK);
      if (done) got = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
  endtask

  task automatic wait_wr_ready(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge CLK);
      if (wr_ready) got = 1'b1;
    end
    check({tag, "_wr_ready"}, 32'(got), 32'd1);
  endtask

  logic [7:0] exp_wr [7];
  int base, bad, accepts, mism;

  initial begin
    exp_wr[0] = 8'h01; exp_wr[1] = 8'h01; exp_wr[2] = 8'h23; exp_wr[3] = 8'hEF;
    exp_wr[4] = 8'hBE; exp_wr[5] = 8'h34; exp_wr[6] = 8'h12;
    RST = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_ss", 32'(SS), 32'd1);
    check("rst_sclk", 32'(SCLK), 32'd0);
    check("rst_qd_out", 32'(QD_OUT), 32'd0);
    check("rst_qd_oe", 32'(QD_OE), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    RST = 1'b0;
    settle(2);

    // Two-word write to 0x123.
    base = done_cnt;
    wr_data = 16'hBEEF; wr_valid = 1'b1;
    issue("wr1", 1'b1, 12'h123, 8'd1);
    check("wr1_busy", 32'(busy), 32'd1);
    wait_wr_ready("wr1_w0");
    wr_data = 16'h1234;
    wait_wr_ready("wr1_w1");
    wr_valid = 1'b0;
    wait_done("wr1", 3000);
    settle(3);
    check("wr1_nbytes", 32'(byte_log.size()), 32'd7);
    for (int i = 0; i < 7 && i < byte_log.size(); i++)
      check($sformatf("wr1_byte%0d", i), 32'(byte_log[i]), 32'(exp_wr[i]));
    check("wr1_rises", 32'(rises), 32'd28);
    check("wr1_mem123", 32'(mem[12'h123]), 32'hBEEF);
    check("wr1_mem124", 32'(mem[12'h124]), 32'h1234);
    check("wr1_done_once", 32'(done_cnt - base), 32'd1);
    check("wr1_idle_ready", 32'(cmd_ready), 32'd1);

    // Read back the two words.
    base = done_cnt;
    issue("rd1", 1'b0, 12'h123, 8'd1);
    wait_done("rd1", 3000);
    settle(3);
    check("rd1_cmd", 32'(byte_log[0]), 32'h02);
    check("rd1_rises", 32'(rises), 32'd32);
    check("rd1_nwords", 32'(rdq.size()), 32'd2);
    if (rdq.size() == 2) begin
      check("rd1_w0", 32'(rdq[0]), 32'hBEEF);
      check("rd1_w1", 32'(rdq[1]), 32'h1234);
    end
    check("rd1_done_once", 32'(done_cnt - base), 32'd1);

    // Write stall: no write word offered for 50 CLKs.
    base = done_cnt;
    wr_valid = 1'b0;
    issue("stall", 1'b1, 12'h200, 8'd0);
    for (int i = 0; i < 2000 && byte_log.size() < 3; i++) @(negedge CLK);
    check("stall_addr_sent", 32'(byte_log.size()), 32'd3);
    repeat (8) @(negedge CLK);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (SCLK !== 1'b0 || SS !== 1'b0) bad++;
    end
    check("stall_lines_held", 32'(bad), 32'd0);
    check("stall_no_bits", 32'(rises), 32'd12);
    @(negedge CLK);
    wr_data = 16'h5A5A; wr_valid = 1'b1;
    wait_wr_ready("stall_w0");
    wr_valid = 1'b0;
    wait_done("stall", 3000);
    settle(3);
    check("stall_mem200", 32'(mem[12'h200]), 32'h5A5A);
    check("stall_rises", 32'(rises), 32'd20);
    check("stall_done_once", 32'(done_cnt - base), 32'd1);

    // 256-word read wrapping past the top of the address space.
    issue("long", 1'b0, 12'hFFF, 8'd255);
    wait_done("long", 20000);
    settle(3);
    check("long_nwords", 32'(rdq.size()), 32'd256);
    if (rdq.size() == 256) begin
      check("long_first", 32'(rdq[0]), 32'hC3A5);
      check("long_wrap", 32'(rdq[1]), 32'h3C5A);
      check("long_last", 32'(rdq[255]), 32'hDCA4);
      mism = 0;
      for (int k = 0; k < 256; k++)
        if (rdq[k] !== pat(12'(12'hFFF + 12'(k)))) mism++;
      check("long_all_words", 32'(mism), 32'd0);
    end

    // Reset during a read after the third word.
    base = done_cnt;
    issue("rstmid", 1'b0, 12'h010, 8'd9);
    for (int i = 0; i < 3000 && rdq.size() < 3; i++) @(negedge CLK);
    check("rstmid_3words", 32'(rdq.size() >= 3), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check("rstmid_ss", 32'(SS), 32'd1);
    check("rstmid_sclk", 32'(SCLK), 32'd0);
    check("rstmid_qd_oe", 32'(QD_OE), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    RST = 1'b0;
    settle(20);
    check("rstmid_no_done", 32'(done_cnt - base), 32'd0);
    base = done_cnt;
    issue("after_rst", 1'b0, 12'h123, 8'd0);
    wait_done("after_rst", 3000);
    settle(3);
    check("after_rst_nwords", 32'(rdq.size()), 32'd1);
    if (rdq.size() == 1) check("after_rst_w0", 32'(rdq[0]), 32'hBEEF);
    check("after_rst_done_once", 32'(done_cnt - base), 32'd1);

    // Back-to-back reads with cmd_valid held.
    base = done_cnt;
    rdq.delete();
    @(negedge CLK);
    gap_min = 1000;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h124; cmd_len = 8'd0;
    accepts = 0;
    for (int i = 0; i < 5000 && accepts < 2; i++) begin
      @(negedge CLK);
      if (cmd_ready) accepts++;
    end
    @(negedge CLK);
    cmd_valid = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'd2);
    for (int i = 0; i < 3000 && (done_cnt - base) < 2; i++) settle(1);
    settle(3);
    check("b2b_done_twice", 32'(done_cnt - base), 32'd2);
    check("b2b_gap_ge_ss_gap", 32'(gap_min >= 4), 32'd1);
    check("b2b_nwords", 32'(rdq.size()), 32'd2);
    if (rdq.size() == 2) begin
      check("b2b_w0", 32'(rdq[0]), 32'h1234);
      check("b2b_w1", 32'(rdq[1]), 32'h1234);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
